// File: rtl/hop_scan_ctrl_pkg.sv
// Shared types and constants for the hop/tuning scan-chain loader.
// Optional build macro: HOP_SCAN_ONESHOT_EN (one frame per reset).
package hop_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } hop_state_e;

  // Position of a bit's four cycles; phi and phi_bar are separated by a dead cycle.
  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_PHI   = 2'd1;
  localparam logic [1:0] PH_GAP   = 2'd2;
  localparam logic [1:0] PH_PHIB  = 2'd3;

  localparam int DATA_W_DEF      = 64;
  localparam int LOAD_CYCLES_DEF = 4;

endpackage

// File: rtl/hop_scan_ctrl_if.sv
// Host-data / chip-scan-pin bundle for hop_scan_ctrl.
// master = the controller, slave = host register block plus chip pins.
interface hop_scan_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
);
  logic [DATA_W-1:0] data_in;
  logic              scan_id;
  logic              scan_phi;
  logic              scan_phi_bar;
  logic              scan_data_in;
  logic              scan_load_chip;
  logic [CNT_W-1:0]  nbits_cnt;
  logic [1:0]        scan_chk;

  modport master (
    input  data_in,
    output scan_id, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, nbits_cnt, scan_chk
  );

  modport slave (
    output data_in,
    input  scan_id, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, nbits_cnt, scan_chk
  );
endinterface

// File: rtl/hop_scan_ctrl_phase_gen.sv
// Per-bit phase counter and registered two-phase scan clock decode.
// bit_done_o marks the last (phi_bar) cycle of each bit.
module hop_scan_phase_gen
  import hop_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_now_i,
  input  logic       shift_next_i,
  output logic [1:0] phase_o,
  output logic       phi_o,
  output logic       phi_bar_o,
  output logic       bit_done_o
);

  logic [1:0] phase_q, phase_d;
  logic       phi_q, phi_d;
  logic       phib_q, phib_d;

  // Clocks are decoded from the upcoming phase so they line up with phase_q.
  always_comb begin
    phase_d = shift_now_i ? (phase_q + 2'd1) : PH_SETUP;
    phi_d   = shift_next_i && (phase_d == PH_PHI);
    phib_d  = shift_next_i && (phase_d == PH_PHIB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_SETUP;
      phi_q   <= 1'b0;
      phib_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      phi_q   <= phi_d;
      phib_q  <= phib_d;
    end
  end

  assign phase_o    = phase_q;
  assign phi_o      = phi_q;
  assign phi_bar_o  = phib_q;
  assign bit_done_o = shift_now_i && (phase_q == PH_PHIB);

endmodule

// File: rtl/hop_scan_ctrl.sv
// Scan-chain loader: capture a config word, shift it MSB-first with two-phase
// scan clocks, then strobe scan_load_chip. Optional macro: HOP_SCAN_ONESHOT_EN.
module hop_scan_ctrl
  import hop_scan_pkg::*;
#(
  parameter int   DATA_W      = DATA_W_DEF,
  parameter int   CNT_W       = 6,
  parameter int   LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter logic SCAN_ID_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  hop_scan_ctrl_if.master bus
);

  localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  hop_state_e        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  nbits_q, nbits_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic              sdata_q, sdata_d;
  logic              load_q, load_d;
  logic              id_q, id_d;
  logic [1:0]        phase;
  logic              phi, phib, bit_done;

  hop_scan_phase_gen u_phase (
    .clk          (clk),
    .reset        (reset),
    .shift_now_i  (state_q == ST_SHIFT),
    .shift_next_i (state_d == ST_SHIFT),
    .phase_o      (phase),
    .phi_o        (phi),
    .phi_bar_o    (phib),
    .bit_done_o   (bit_done)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    nbits_d = nbits_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_IDLE: begin
        sr_d    = bus.data_in;
        nbits_d = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_done) begin
          sr_d    = {sr_q[DATA_W-2:0], 1'b0};
          // Last bit wraps the counter back to 0 naturally.
          nbits_d = nbits_q + 1'b1;
          if (nbits_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_LOAD;
            lcnt_d  = '0;
          end
        end
      end
      ST_LOAD: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == LC_W'(LOAD_CYCLES - 1)) begin
`ifdef HOP_SCAN_ONESHOT_EN
          state_d = ST_DONE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered against the state being entered.
    sdata_d = (state_d == ST_SHIFT) && sr_d[DATA_W-1];
    load_d  = (state_d == ST_LOAD);
    id_d    = ((state_d == ST_SHIFT) || (state_d == ST_LOAD)) ? SCAN_ID_VAL : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      nbits_q <= '0;
      lcnt_q  <= '0;
      sdata_q <= 1'b0;
      load_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      nbits_q <= nbits_d;
      lcnt_q  <= lcnt_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      id_q    <= id_d;
    end
  end

  assign bus.scan_id        = id_q;
  assign bus.scan_phi       = phi;
  assign bus.scan_phi_bar   = phib;
  assign bus.scan_data_in   = sdata_q;
  assign bus.scan_load_chip = load_q;
  assign bus.nbits_cnt      = nbits_q;
  assign bus.scan_chk       = phase;

endmodule

// File: tb/tb_hop_scan_ctrl.sv
// Randomized bench for hop_scan_ctrl against a frame-position reference model.
// Honours HOP_SCAN_ONESHOT_EN when defined.
module tb_hop_scan_ctrl;

  localparam int   DW    = 64;
  localparam int   LOADC = 4;
  localparam int   FRAME = 1 + 4 * DW + LOADC;
  localparam logic SIDV  = 1'b0;

  logic clk;
  logic reset;

  hop_scan_ctrl_if #(.DATA_W(DW), .CNT_W(6)) bus ();

  hop_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          k;
  logic [63:0] cur_word;
  int          phi_n, phib_n, load_n;
  logic        prev_phi, prev_phib;
  logic [63:0] recon, first_recon, last_recon;
  int          frames_done;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {scan_id, phi, phi_bar, data, load, nbits[5:0], chk[1:0]} after kk edges.
  function automatic logic [12:0] exp_vec(input int kk, input logic [63:0] w);
    int          pos, b, ph;
    logic [12:0] v;
    v = '0;
`ifdef HOP_SCAN_ONESHOT_EN
    if (kk >= FRAME) return v;
`endif
    pos = kk % FRAME;
    if (pos >= 1 && pos <= 4 * DW) begin
      b = (pos - 1) / 4;
      ph = (pos - 1) % 4;
      v[12]  = SIDV;
      v[11]  = (ph == 1);
      v[10]  = (ph == 3);
      v[9]   = w[DW - 1 - b];
      v[7:2] = b[5:0];
      v[1:0] = ph[1:0];
    end else if (pos > 4 * DW) begin
      v[12] = SIDV;
      v[8]  = 1'b1;
    end
    return v;
  endfunction

  function automatic bit capture_at(input int kk);
`ifdef HOP_SCAN_ONESHOT_EN
    return kk == 0;
`else
    return (kk % FRAME) == 0;
`endif
  endfunction

  function automatic bit frame_end_at(input int kk);
`ifdef HOP_SCAN_ONESHOT_EN
    return kk == FRAME;
`else
    return (kk > 0) && ((kk % FRAME) == 0);
`endif
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.scan_id, bus.scan_phi, bus.scan_phi_bar, bus.scan_data_in,
            bus.scan_load_chip, bus.nbits_cnt, bus.scan_chk};
  endfunction

  task automatic clear_stats();
    phi_n = 0; phib_n = 0; load_n = 0;
    prev_phi = 1'b0; prev_phib = 1'b0;
    recon = '0;
  endtask

  task automatic tick();
    logic [12:0] obs;
    @(posedge clk);
    if (capture_at(k)) cur_word = bus.data_in;
    k++;
    @(negedge clk);
    obs = obs_vec();
    check_val($sformatf("cycle%0d", k), 64'(obs), 64'(exp_vec(k, cur_word)));
    check_val("overlap", 64'(bus.scan_phi & bus.scan_phi_bar), 64'd0);
    if (bus.scan_phi && !prev_phi) begin
      phi_n++;
      recon = {recon[62:0], bus.scan_data_in};
    end
    if (bus.scan_phi_bar && !prev_phib) phib_n++;
    if (bus.scan_load_chip) load_n++;
    prev_phi  = bus.scan_phi;
    prev_phib = bus.scan_phi_bar;
    if (frame_end_at(k)) begin
      check_val("phi_pulses", 64'(phi_n), 64'(DW));
      check_val("phib_pulses", 64'(phib_n), 64'(DW));
      check_val("load_cycles", 64'(load_n), 64'(LOADC));
      check_val("recon_word", recon, cur_word);
      frames_done++;
      if (frames_done == 1) first_recon = recon;
      last_recon = recon;
      clear_stats();
    end
  endtask

  // Called at a falling edge: async assert mid-cycle, release on a later falling edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_val("async_rst", 64'(obs_vec()), 64'd0);
    @(negedge clk);
    check_val("rst_held", 64'(obs_vec()), 64'd0);
    reset = 1'b1;
    k = 0;
    clear_stats();
  endtask

  initial begin
    bit found;
    total = 0; bad = 0; k = 0; frames_done = 0;
    cur_word = '0; first_recon = '0; last_recon = '0;
    clear_stats();
    reset = 1'b0;
    bus.data_in = '0;
    #100;
    check_val("rst_outputs", 64'(obs_vec()), 64'd0);
    bus.data_in = 64'h02AAAAAAAAAAAAAA;
    reset = 1'b1;

    // Frame 1 with a mid-frame data change that must not disturb it.
    for (int c = 0; c < 130; c++) tick();
    bus.data_in = 64'hFFFF000000000000;
    for (int c = 130; c < FRAME; c++) tick();
    check_val("pattern_word", first_recon, 64'h02AAAAAAAAAAAAAA);

    for (int c = 0; c < FRAME; c++) tick();
`ifndef HOP_SCAN_ONESHOT_EN
    check_val("updated_word", last_recon, 64'hFFFF000000000000);
`endif

    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        tick();
        if ($urandom_range(0, 59) == 0) bus.data_in = {$urandom, $urandom};
      end
    end

`ifdef HOP_SCAN_ONESHOT_EN
    do_reset();
`endif
    // Abort mid-frame while phi is high on bit 20.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if ((k % FRAME) == 1 + 4 * 20 + 1) found = 1'b1;
    end
    check_val("rst_wait", 64'(found), 64'd1);
    do_reset();

    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      if ($urandom_range(0, 49) == 0) bus.data_in = {$urandom, $urandom};
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
